gpio_tri_bank: RTL

Parametrised multi-channel bidirectional pad bank. It generalises the single-channel SWDIO tristate buffer to CH channels. Each channel adds:
- a registered output path with configurable bus-turnaround delay before the pad is driven;
- a metastability synchroniser on the input path;
- a stability (glitch) filter;
- rise and fall edge-detect pulses.

The bank sits between SoC peripherals (SWD, GPIO, bit-banged serial) and the FPGA pins. It instantiates one Xilinx IOBUF per channel; the IOBUF T input is 1 for hi-Z and 0 for drive.

---
 rtl/gpio_tri_bank.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/gpio_tri_bank.sv
// Multi-channel bidirectional pad bank: registered output with bus turnaround,
// synchronised and glitch-filtered input with rise/fall edge pulses.
module gpio_tri_bank #(
    parameter int CH          = 4,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 3,
    parameter int TURN_CYC    = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [CH-1:0] out_data,
    input  logic [CH-1:0] out_en,
    output logic [CH-1:0] in_data,
    output logic [CH-1:0] in_rise,
    output logic [CH-1:0] in_fall,
    output logic [CH-1:0] drive_active,
    inout  wire  [CH-1:0] pad_io
);

    localparam int                CNT_W     = $clog2(FILT_LEN + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(FILT_LEN - 1);
    localparam logic [3:0]        TURN_LOAD = (TURN_CYC > 0) ? 4'(TURN_CYC - 1) : 4'd0;

    typedef enum logic [1:0] {
        HIZ,
        TURN,
        DRIVE
    } drv_state_e;

    logic [CH-1:0] out_q;
    logic [CH-1:0] pad_t;
    logic [CH-1:0] sync_q [SYNC_STAGES];

    // Output register feeds the IOBUF I input regardless of out_en.
    always_ff @(posedge clk) begin
        if (rst) out_q <= '0;
        else     out_q <= out_data;
    end

    // NOTE: the synchroniser chain is an array but still gets an explicit
    // reset, otherwise a reset would not clear a pending input transition.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= pad_io;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign pad_t = ~drive_active;

    for (genvar c = 0; c < CH; c++) begin : g_ch
        drv_state_e       state;
        logic [3:0]       turn_cnt;
        logic             drive_q;
        logic [CNT_W-1:0] filt_cnt;
        logic             in_q;
        logic             rise_q;
        logic             fall_q;
        logic             s;

        assign s = sync_q[SYNC_STAGES-1][c];

        // Drive FSM: turnaround on request, immediate release.
        always_ff @(posedge clk) begin
            if (rst) begin
                state    <= HIZ;
                turn_cnt <= 4'd0;
                drive_q  <= 1'b0;
            end else begin
                case (state)
                    HIZ: begin
                        if (out_en[c]) begin
                            if (TURN_CYC == 0) begin
                                state   <= DRIVE;
                                drive_q <= 1'b1;
                            end else begin
                                state    <= TURN;
                                turn_cnt <= TURN_LOAD;
                            end
                        end
                    end
                    TURN: begin
                        if (!out_en[c]) begin
                            state <= HIZ;
                        end else if (turn_cnt == 4'd0) begin
                            state   <= DRIVE;
                            drive_q <= 1'b1;
                        end else begin
                            turn_cnt <= turn_cnt - 4'd1;
                        end
                    end
                    DRIVE: begin
                        if (!out_en[c]) begin
                            state   <= HIZ;
                            drive_q <= 1'b0;
                        end
                    end
                    default: begin
                        state   <= HIZ;
                        drive_q <= 1'b0;
                    end
                endcase
            end
        end

        // Stability filter: accept s only after FILT_LEN consecutive differing samples.
        always_ff @(posedge clk) begin
            if (rst) begin
                filt_cnt <= '0;
                in_q     <= 1'b0;
                rise_q   <= 1'b0;
                fall_q   <= 1'b0;
            end else begin
                rise_q <= 1'b0;
                fall_q <= 1'b0;
                if (s == in_q) begin
                    filt_cnt <= '0;
                end else if (filt_cnt == CNT_LAST) begin
                    in_q     <= s;
                    filt_cnt <= '0;
                    rise_q   <= s;
                    fall_q   <= ~s;
                end else begin
                    filt_cnt <= filt_cnt + 1'b1;
                end
            end
        end

        assign drive_active[c] = drive_q;
        assign in_data[c]      = in_q;
        assign in_rise[c]      = rise_q;
        assign in_fall[c]      = fall_q;

        // Synthesis maps this tristate onto one IOBUF (T = pad_t, I = out_q, O = pad_io).
        assign pad_io[c] = pad_t[c] ? 1'bz : out_q[c];
    end

endmodule
